// File: rtl/branch_rs_pkg.sv
// Shared datapath constants for the branch reservation station.
//   ENABLE/DISABLE   : single-bit control levels
//   TAG_FREE         : rename tag meaning "operand value is ready"
//   *_BUS_W          : default datapath widths (data, instruction address, opcode, tag)
//   br_op_e          : conditional branch opcode encodings
package branch_rs_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned DATA_BUS_W      = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned OP_BUS_W        = 6;
  localparam int unsigned TAG_BUS_W       = 4;

  localparam logic [TAG_BUS_W-1:0] TAG_FREE = '0;

  typedef enum logic [OP_BUS_W-1:0] {
    OP_BEQ  = 6'h10,
    OP_BNE  = 6'h11,
    OP_BLT  = 6'h12,
    OP_BGE  = 6'h13,
    OP_BLTU = 6'h14,
    OP_BGEU = 6'h15
  } br_op_e;

endpackage

// File: rtl/branch_rs_sel.sv
// Lowest-index priority encoder.
//   req   : request vector
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one request bit is set
module branch_rs_sel #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station.
// Holds dispatched conditional branches until both operands are known,
// snooping the ALU and LS common data buses, and issues at most one ready
// branch per cycle through registered br_* outputs.
//   clk, rst           : clock, synchronous active-high reset
//   disp_*             : dispatch interface; rs_full (comb) = no free slot
//   alu_cdb_*, ls_cdb_*: result broadcasts (tag + data)
//   mis_taken          : misprediction flush, clears all entries
//   br_*               : registered issue interface to the branch unit
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned DATA_W  = DATA_BUS_W,
  parameter int unsigned ADDR_W  = INST_ADDR_BUS_W,
  parameter int unsigned TAG_W   = TAG_BUS_W,
  parameter int unsigned OP_W    = OP_BUS_W,
  parameter int unsigned BNUM_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [ADDR_W-1:0] disp_pc,
  input  logic [BNUM_W-1:0] disp_bnum,
  input  logic [DATA_W-1:0] disp_valo,
  input  logic [DATA_W-1:0] disp_valt,
  input  logic [TAG_W-1:0]  disp_tago,
  input  logic [TAG_W-1:0]  disp_tagt,
  output logic              rs_full,
  input  logic              alu_cdb_en,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              ls_cdb_en,
  input  logic [TAG_W-1:0]  ls_cdb_tag,
  input  logic [DATA_W-1:0] ls_cdb_data,
  input  logic              mis_taken,
  output logic              br_work_en,
  output logic [DATA_W-1:0] br_operand_o,
  output logic [DATA_W-1:0] br_operand_t,
  output logic [OP_W-1:0]   br_op,
  output logic [DATA_W-1:0] br_imm,
  output logic [ADDR_W-1:0] br_pc,
  output logic [BNUM_W-1:0] br_bnum
);

  localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_FREE);

  logic [ENTRIES-1:0] valid;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [DATA_W-1:0]  imm_q  [ENTRIES];
  logic [ADDR_W-1:0]  pc_q   [ENTRIES];
  logic [BNUM_W-1:0]  bnum_q [ENTRIES];
  logic [DATA_W-1:0]  valo_q [ENTRIES];
  logic [DATA_W-1:0]  valt_q [ENTRIES];
  logic [TAG_W-1:0]   tago_q [ENTRIES];
  logic [TAG_W-1:0]   tagt_q [ENTRIES];

  logic [ENTRIES-1:0] free_vec, ready_vec;
  logic [IW-1:0]      free_idx, rdy_idx;
  logic               free_found, rdy_found;

  logic [DATA_W-1:0]  d_valo, d_valt;
  logic [TAG_W-1:0]   d_tago, d_tagt;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      free_vec[i]  = ~valid[i];
      ready_vec[i] = valid[i] && (tago_q[i] == TAG_NONE) && (tagt_q[i] == TAG_NONE);
    end
  end

  branch_rs_sel #(.N(ENTRIES), .IW(IW)) u_free_sel (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  branch_rs_sel #(.N(ENTRIES), .IW(IW)) u_rdy_sel (
    .req   (ready_vec),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  assign rs_full = ~free_found;

  // Operands broadcast in the dispatch cycle are captured directly; ALU wins on a tag tie.
  always_comb begin
    d_valo = disp_valo;
    d_tago = disp_tago;
    d_valt = disp_valt;
    d_tagt = disp_tagt;
    if (disp_tago != TAG_NONE) begin
      if (alu_cdb_en && alu_cdb_tag == disp_tago) begin
        d_valo = alu_cdb_data;
        d_tago = TAG_NONE;
      end else if (ls_cdb_en && ls_cdb_tag == disp_tago) begin
        d_valo = ls_cdb_data;
        d_tago = TAG_NONE;
      end
    end
    if (disp_tagt != TAG_NONE) begin
      if (alu_cdb_en && alu_cdb_tag == disp_tagt) begin
        d_valt = alu_cdb_data;
        d_tagt = TAG_NONE;
      end else if (ls_cdb_en && ls_cdb_tag == disp_tagt) begin
        d_valt = ls_cdb_data;
        d_tagt = TAG_NONE;
      end
    end
  end

  // The free slot is invalid and the ready slot is valid, so dispatch, snoop
  // and issue never target the same entry within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      br_work_en   <= DISABLE;
      br_operand_o <= '0;
      br_operand_t <= '0;
      br_op        <= '0;
      br_imm       <= '0;
      br_pc        <= '0;
      br_bnum      <= '0;
    end else if (mis_taken) begin
      valid      <= '0;
      br_work_en <= DISABLE;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (valid[i] && tago_q[i] != TAG_NONE) begin
          if (alu_cdb_en && alu_cdb_tag == tago_q[i]) begin
            valo_q[i] <= alu_cdb_data;
            tago_q[i] <= TAG_NONE;
          end else if (ls_cdb_en && ls_cdb_tag == tago_q[i]) begin
            valo_q[i] <= ls_cdb_data;
            tago_q[i] <= TAG_NONE;
          end
        end
        if (valid[i] && tagt_q[i] != TAG_NONE) begin
          if (alu_cdb_en && alu_cdb_tag == tagt_q[i]) begin
            valt_q[i] <= alu_cdb_data;
            tagt_q[i] <= TAG_NONE;
          end else if (ls_cdb_en && ls_cdb_tag == tagt_q[i]) begin
            valt_q[i] <= ls_cdb_data;
            tagt_q[i] <= TAG_NONE;
          end
        end
      end

      br_work_en <= rdy_found ? ENABLE : DISABLE;
      if (rdy_found) begin
        br_operand_o   <= valo_q[rdy_idx];
        br_operand_t   <= valt_q[rdy_idx];
        br_op          <= op_q[rdy_idx];
        br_imm         <= imm_q[rdy_idx];
        br_pc          <= pc_q[rdy_idx];
        br_bnum        <= bnum_q[rdy_idx];
        valid[rdy_idx] <= 1'b0;
      end

      if (disp_en && free_found) begin
        valid[free_idx]  <= 1'b1;
        op_q[free_idx]   <= disp_op;
        imm_q[free_idx]  <= disp_imm;
        pc_q[free_idx]   <= disp_pc;
        bnum_q[free_idx] <= disp_bnum;
        valo_q[free_idx] <= d_valo;
        tago_q[free_idx] <= d_tago;
        valt_q[free_idx] <= d_valt;
        tagt_q[free_idx] <= d_tagt;
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
module tb_branch_rs;
  import branch_rs_pkg::*;

  localparam int ENTRIES = 4;

  logic        clk, rst;
  logic        disp_en;
  logic [5:0]  disp_op;
  logic [31:0] disp_imm, disp_pc, disp_valo, disp_valt;
  logic [1:0]  disp_bnum;
  logic [3:0]  disp_tago, disp_tagt;
  logic        rs_full;
  logic        alu_cdb_en, ls_cdb_en;
  logic [3:0]  alu_cdb_tag, ls_cdb_tag;
  logic [31:0] alu_cdb_data, ls_cdb_data;
  logic        mis_taken;
  logic        br_work_en;
  logic [31:0] br_operand_o, br_operand_t, br_imm, br_pc;
  logic [5:0]  br_op;
  logic [1:0]  br_bnum;

  branch_rs #(.ENTRIES(ENTRIES), .DATA_W(32), .ADDR_W(32), .TAG_W(4), .OP_W(6), .BNUM_W(2)) dut (
    .clk(clk), .rst(rst),
    .disp_en(disp_en), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_bnum(disp_bnum), .disp_valo(disp_valo), .disp_valt(disp_valt),
    .disp_tago(disp_tago), .disp_tagt(disp_tagt), .rs_full(rs_full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .ls_cdb_en(ls_cdb_en), .ls_cdb_tag(ls_cdb_tag), .ls_cdb_data(ls_cdb_data),
    .mis_taken(mis_taken), .br_work_en(br_work_en),
    .br_operand_o(br_operand_o), .br_operand_t(br_operand_t), .br_op(br_op),
    .br_imm(br_imm), .br_pc(br_pc), .br_bnum(br_bnum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit ovf_ok   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Dispatcher protocol: never present a dispatch while the station is full.
  always @(negedge clk)
    if (!rst && !ovf_ok && disp_en)
      assert (!rs_full) else $error("dispatch presented while rs_full");

  // Reference model: a table of pending branches.
  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [31:0] imm, pc, valo, valt;
    logic [1:0]  bnum;
    logic [3:0]  tago, tagt;
  } ent_t;

  ent_t        m[ENTRIES];
  logic        e_en;
  logic [31:0] e_o, e_t, e_imm, e_pc;
  logic [5:0]  e_op;
  logic [1:0]  e_bnum;

  function automatic int m_free();
    for (int i = 0; i < ENTRIES; i++) if (!m[i].v) return i;
    return -1;
  endfunction

  function automatic int m_ready();
    for (int i = 0; i < ENTRIES; i++) if (m[i].v && m[i].tago == 0 && m[i].tagt == 0) return i;
    return -1;
  endfunction

  task automatic resolve(inout logic [3:0] tag, inout logic [31:0] val);
    if (tag != 0) begin
      if (alu_cdb_en && alu_cdb_tag == tag) begin val = alu_cdb_data; tag = 0; end
      else if (ls_cdb_en && ls_cdb_tag == tag) begin val = ls_cdb_data; tag = 0; end
    end
  endtask

  task automatic model_edge();
    int f, r;
    logic [3:0]  t;
    logic [31:0] v;
    f = m_free();
    r = m_ready();
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m[i].v = 0;
      e_en = 0; e_o = 0; e_t = 0; e_imm = 0; e_pc = 0; e_op = 0; e_bnum = 0;
    end else if (mis_taken) begin
      for (int i = 0; i < ENTRIES; i++) m[i].v = 0;
      e_en = 0;
    end else begin
      e_en = (r >= 0);
      if (r >= 0) begin
        e_o = m[r].valo; e_t = m[r].valt; e_op = m[r].op;
        e_imm = m[r].imm; e_pc = m[r].pc; e_bnum = m[r].bnum;
        m[r].v = 0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (m[i].v) begin
          t = m[i].tago; v = m[i].valo; resolve(t, v); m[i].tago = t; m[i].valo = v;
          t = m[i].tagt; v = m[i].valt; resolve(t, v); m[i].tagt = t; m[i].valt = v;
        end
      end
      if (disp_en && f >= 0) begin
        m[f].v = 1; m[f].op = disp_op; m[f].imm = disp_imm; m[f].pc = disp_pc;
        m[f].bnum = disp_bnum;
        t = disp_tago; v = disp_valo; resolve(t, v); m[f].tago = t; m[f].valo = v;
        t = disp_tagt; v = disp_valt; resolve(t, v); m[f].tagt = t; m[f].valt = v;
      end
    end
  endtask

  // One clock: check rs_full mid-cycle, advance the model, check outputs after the edge.
  task automatic cycle();
    #4;
    check_eq("rs_full", rs_full, (m_free() < 0));
    model_edge();
    @(posedge clk);
    #1;
    check_eq("br_work_en", br_work_en, e_en);
    check_eq("br_operand_o", br_operand_o, e_o);
    check_eq("br_operand_t", br_operand_t, e_t);
    check_eq("br_op", br_op, e_op);
    check_eq("br_imm", br_imm, e_imm);
    check_eq("br_pc", br_pc, e_pc);
    check_eq("br_bnum", br_bnum, e_bnum);
  endtask

  task automatic idle();
    disp_en = 0; alu_cdb_en = 0; ls_cdb_en = 0; mis_taken = 0; rst = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] vo, input logic [3:0] to,
                      input logic [31:0] vt, input logic [3:0] tt);
    disp_en = 1; disp_op = op; disp_pc = pc; disp_imm = imm; disp_bnum = pc[3:2];
    disp_valo = vo; disp_tago = to; disp_valt = vt; disp_tagt = tt;
  endtask

  initial begin
    idle();
    disp_op = 0; disp_imm = 0; disp_pc = 0; disp_bnum = 0;
    disp_valo = 0; disp_valt = 0; disp_tago = 0; disp_tagt = 0;
    alu_cdb_tag = 0; alu_cdb_data = 0; ls_cdb_tag = 0; ls_cdb_data = 0;
    for (int i = 0; i < ENTRIES; i++) m[i].v = 0;
    e_en = 0; e_o = 0; e_t = 0; e_imm = 0; e_pc = 0; e_op = 0; e_bnum = 0;
    @(posedge clk); #1;

    // Reset state
    rst = 1; cycle(); cycle();
    idle();
    check_eq("reset_en", br_work_en, 1'b0);
    check_eq("reset_pc", br_pc, 32'h0);
    #4; check_eq("reset_full", rs_full, 1'b0); #1;
    @(posedge clk); #1;

    // Ready dispatch: issue after the second edge, one cycle wide
    disp(OP_BEQ, 32'h100, 32'h20, 32'd5, 4'd0, 32'd5, 4'd0); cycle();
    idle(); check_eq("t1_no_early", br_work_en, 1'b0);
    cycle();
    check_eq("t1_en", br_work_en, 1'b1);
    check_eq("t1_opo", br_operand_o, 32'd5);
    check_eq("t1_pc", br_pc, 32'h100);
    check_eq("t1_imm", br_imm, 32'h20);
    cycle(); check_eq("t1_pulse", br_work_en, 1'b0);

    // Snoop wakeup
    disp(OP_BLT, 32'h104, 32'h8, 32'd0, 4'd3, 32'd7, 4'd0); cycle();
    idle();
    for (int i = 0; i < 3; i++) begin cycle(); check_eq("t2_hold", br_work_en, 1'b0); end
    alu_cdb_en = 1; alu_cdb_tag = 4'd3; alu_cdb_data = 32'hFFFF_FFFF; cycle();
    idle(); check_eq("t2_not_same_edge", br_work_en, 1'b0);
    cycle();
    check_eq("t2_en", br_work_en, 1'b1);
    check_eq("t2_opo", br_operand_o, 32'hFFFF_FFFF);
    check_eq("t2_opt", br_operand_t, 32'd7);

    // Dispatch forwarding from LS CDB
    disp(OP_BNE, 32'h108, 32'h4, 32'd1, 4'd0, 32'd0, 4'd5);
    ls_cdb_en = 1; ls_cdb_tag = 4'd5; ls_cdb_data = 32'h42; cycle();
    idle(); cycle();
    check_eq("t3_en", br_work_en, 1'b1);
    check_eq("t3_opt", br_operand_t, 32'h42);

    // Fill, overflow ignored, ordered wakeup
    for (int i = 0; i < 4; i++) begin
      disp(OP_BGE, 32'h200 + 32'(i * 4), 32'h10, 32'd0, 4'(i + 1), 32'd9, 4'd0); cycle();
    end
    idle();
    #4; check_eq("t4_full", rs_full, 1'b1); #1; @(posedge clk); #1;
    ovf_ok = 1;
    disp(OP_BEQ, 32'h300, 32'h0, 32'd1, 4'd0, 32'd1, 4'd0); cycle();
    ovf_ok = 0; idle();
    check_eq("t4_ovf_ignored", br_work_en, 1'b0);
    alu_cdb_en = 1; alu_cdb_tag = 4'd3; alu_cdb_data = 32'h33;
    ls_cdb_en  = 1; ls_cdb_tag  = 4'd1; ls_cdb_data  = 32'h11; cycle();
    idle(); cycle();
    check_eq("t4_first", br_pc, 32'h200);
    check_eq("t4_first_opo", br_operand_o, 32'h11);
    cycle();
    check_eq("t4_second", br_pc, 32'h208);
    check_eq("t4_second_en", br_work_en, 1'b1);

    // Flush: two pending (tags 2,4) plus one ready, flush with dispatch
    disp(OP_BLTU, 32'h400, 32'h0, 32'd2, 4'd0, 32'd3, 4'd0); cycle();
    mis_taken = 1; disp(OP_BEQ, 32'h404, 32'h0, 32'd0, 4'd0, 32'd0, 4'd0); cycle();
    idle(); check_eq("t5_en", br_work_en, 1'b0);
    #4; check_eq("t5_empty", rs_full, 1'b0); #1; @(posedge clk); #1;
    alu_cdb_en = 1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'h1;
    ls_cdb_en  = 1; ls_cdb_tag  = 4'd4; ls_cdb_data  = 32'h2; cycle();
    idle(); cycle(); check_eq("t5_no_ghost", br_work_en, 1'b0);
    cycle(); check_eq("t5_no_ghost2", br_work_en, 1'b0);

    // Reset mid-operation
    disp(OP_BGEU, 32'h500, 32'h0, 32'd0, 4'd6, 32'd0, 4'd0); cycle();
    disp(OP_BGEU, 32'h504, 32'h0, 32'd0, 4'd7, 32'd0, 4'd0); cycle();
    disp(OP_BNE, 32'h508, 32'h0, 32'd4, 4'd0, 32'd4, 4'd0); cycle();
    idle(); cycle();
    check_eq("t6_issuing", br_work_en, 1'b1);
    rst = 1; cycle();
    idle();
    check_eq("t6_en", br_work_en, 1'b0);
    check_eq("t6_pc", br_pc, 32'h0);
    check_eq("t6_opo", br_operand_o, 32'h0);
    disp(OP_BEQ, 32'h600, 32'h4, 32'd8, 4'd0, 32'd8, 4'd0); cycle();
    idle(); cycle();
    check_eq("t6_fresh", br_work_en, 1'b1);
    check_eq("t6_fresh_pc", br_pc, 32'h600);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      if (($urandom % 3 != 0) && m_free() >= 0) begin
        disp(6'(int'(OP_BEQ) + int'($urandom_range(0, 5))), $urandom, $urandom,
             $urandom, ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
             $urandom, ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 7)));
      end
      alu_cdb_en   = ($urandom % 2 == 0);
      alu_cdb_tag  = 4'($urandom_range(1, 7));
      alu_cdb_data = $urandom;
      ls_cdb_en    = ($urandom % 2 == 0);
      ls_cdb_tag   = 4'($urandom_range(1, 7));
      if (ls_cdb_tag == alu_cdb_tag) ls_cdb_tag = (alu_cdb_tag == 4'd7) ? 4'd1 : alu_cdb_tag + 4'd1;
      ls_cdb_data  = $urandom;
      mis_taken    = ($urandom % 40 == 0);
      rst          = ($urandom % 200 == 0);
      cycle();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
